// File: rtl/filter_capture_if.sv
// filter_capture_if: bundles the command, sample-input, readout and status signals of
// filter_capture.
//   master : drives start, sample_valid/sample_lp/sample_hp and rd_req/rd_addr;
//            observes rd_lp/rd_hp/rd_valid, busy, done, count and the two peaks.
//   slave  : the capture buffer side (directions reversed).
// Samples are 32-bit sign-magnitude: bit 31 is the sign, bits 30:0 the magnitude.
interface filter_capture_if #(
    parameter int unsigned DEPTH_LOG2 = 15
) ();
    logic                  start;
    logic                  sample_valid;
    logic [31:0]           sample_lp;
    logic [31:0]           sample_hp;
    logic                  rd_req;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [31:0]           rd_lp;
    logic [31:0]           rd_hp;
    logic                  rd_valid;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2:0]   count;
    logic [30:0]           lp_peak;
    logic [30:0]           hp_peak;

    modport master (
        output start, sample_valid, sample_lp, sample_hp, rd_req, rd_addr,
        input  rd_lp, rd_hp, rd_valid, busy, done, count, lp_peak, hp_peak
    );

    modport slave (
        input  start, sample_valid, sample_lp, sample_hp, rd_req, rd_addr,
        output rd_lp, rd_hp, rd_valid, busy, done, count, lp_peak, hp_peak
    );
endinterface

// File: rtl/filter_capture.sv
// filter_capture: capture buffer behind the low-pass/high-pass IIR filter pair.
// A start pulse discards SETTLE valid samples, then stores 2^DEPTH_LOG2 sample pairs
// into a simple dual-port RAM while tracking the peak magnitude of each channel.
// Once the block is complete the RAM is readable at random addresses (latency 1).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (overrides every other input)
//   bus  - filter_capture_if.slave: start, sample_valid/sample_lp/sample_hp in;
//          rd_req/rd_addr in, rd_lp/rd_hp/rd_valid out; busy, done, count,
//          lp_peak, hp_peak status out.
module filter_capture #(
    parameter int unsigned DEPTH_LOG2 = 15,
    parameter int unsigned SETTLE     = 8
) (
    input  logic            clk,
    input  logic            rst,
    filter_capture_if.slave bus
);
    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    // Only meaningful when SETTLE > 0; SETTLE == 0 bypasses the settle state.
    localparam logic [7:0]            SettleLast = 8'(SETTLE - 1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne     = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CntOne     = (DEPTH_LOG2 + 1)'(1);

    typedef enum logic [1:0] {StIdle, StSettle, StCapture, StDone} state_e;

    state_e                state;
    logic                  busy;
    logic                  done;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [7:0]            settle_cnt;
    logic [DEPTH_LOG2:0]   count;
    logic [30:0]           lp_peak;
    logic [30:0]           hp_peak;

    logic [63:0]           mem [Depth];
    logic [63:0]           rd_data;
    logic                  rd_valid;

    logic                  restart;
    logic                  wr_en;
    logic                  rd_en;

    // Command decode; rst and start both take priority over a read in DONE.
    always_comb begin
        restart = !rst && bus.start && (state == StIdle || state == StDone);
        wr_en   = !rst && bus.sample_valid && (state == StCapture);
        rd_en   = !rst && bus.rd_req && !bus.start && (state == StDone);
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ptr     <= '0;
            settle_cnt <= '0;
            count      <= '0;
            lp_peak    <= '0;
            hp_peak    <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (restart) begin
                        state      <= (SETTLE > 0) ? StSettle : StCapture;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        wr_ptr     <= '0;
                        settle_cnt <= '0;
                        count      <= '0;
                        lp_peak    <= '0;
                        hp_peak    <= '0;
                    end
                end
                StSettle: begin
                    if (bus.sample_valid) begin
                        settle_cnt <= settle_cnt + 8'd1;
                        // The SETTLE-th valid sample is discarded too.
                        if (settle_cnt == SettleLast) begin
                            state <= StCapture;
                        end
                    end
                end
                StCapture: begin
                    if (wr_en) begin
                        wr_ptr <= wr_ptr + PtrOne;
                        count  <= count + CntOne;
                        // Sign bit ignored, so -0 contributes magnitude 0.
                        if (bus.sample_lp[30:0] > lp_peak) begin
                            lp_peak <= bus.sample_lp[30:0];
                        end
                        if (bus.sample_hp[30:0] > hp_peak) begin
                            hp_peak <= bus.sample_hp[30:0];
                        end
                        if (wr_ptr == '1) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Sample RAM: never cleared, written only during CAPTURE.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {bus.sample_lp, bus.sample_hp};
        end
    end

    // Registered read port; data holds between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[bus.rd_addr];
            end
        end
    end

    assign bus.rd_lp    = rd_data[63:32];
    assign bus.rd_hp    = rd_data[31:0];
    assign bus.rd_valid = rd_valid;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.count    = count;
    assign bus.lp_peak  = lp_peak;
    assign bus.hp_peak  = hp_peak;
endmodule

// File: doc/filter_capture.md
# filter_capture

Capture buffer that sits downstream of the low-pass/high-pass IIR filter pair. On command it discards a programmable number of filter-settling samples. It then writes a fixed-length block of paired 32-bit sign-magnitude outputs into on-chip RAM and tracks the peak magnitude per channel. Once the block is complete it serves random-access reads, making it the write/readout counterpart to the ROM sample source that feeds the filters.

## Interface
Parameters:
- DEPTH_LOG2, 15, log2 of capture length; buffer holds 2^DEPTH_LOG2 sample pairs.
- SETTLE, 8, number of valid samples discarded after start, 0..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse that begins a capture; honoured only in IDLE or DONE.
- sample_valid  in  1  sample_lp/sample_hp hold a new pair this cycle.
- sample_lp  in  32  low-pass output; bit 31 is the sign, bits 30:0 the magnitude.
- sample_hp  in  32  high-pass output, same format.
- rd_req  in  1  read request; honoured only in DONE.
- rd_addr  in  DEPTH_LOG2  read index, 0 is the oldest sample.
- rd_lp  out  32  stored low-pass word.
- rd_hp  out  32  stored high-pass word.
- rd_valid  out  1  rd_lp/rd_hp are valid this cycle.
- busy  out  1  high in SETTLE or CAPTURE.
- done  out  1  high in DONE.
- count  out  DEPTH_LOG2+1  pairs written in the current or last capture.
- lp_peak  out  31  maximum low-pass magnitude over the captured block.
- hp_peak  out  31  maximum high-pass magnitude over the captured block.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, start=1 -> SETTLE if SETTLE>0, else CAPTURE. The same edge clears count, lp_peak, hp_peak, the write pointer and the settle counter.
- SETTLE: each sample_valid increments the settle counter. On the SETTLE-th valid sample -> CAPTURE; that sample is not stored.
- CAPTURE: each sample_valid writes {sample_lp, sample_hp} at the write pointer, increments the pointer (DEPTH_LOG2 bits) and increments count.
  - Peaks update with max(peak, bits[30:0]); sign is ignored, so -0 counts as magnitude 0.
  - The write that brings count to 2^DEPTH_LOG2 (pointer wraps to 0) -> DONE.
- DONE: start=1 restarts exactly as from IDLE. rd_req=1 reads address rd_addr.
- start in SETTLE or CAPTURE is ignored.
- rd_req outside DONE is ignored.
- If start and rd_req coincide in DONE, start wins and the read is dropped.
- sample_valid in IDLE or DONE is ignored.
- Memory contents are never cleared: not by rst, not by start.
- Inferred as a simple dual-port synchronous RAM, DEPTH x 64 bits.

## Timing
- Reset values: state IDLE, busy 0, done 0, rd_valid 0, rd_lp 0, rd_hp 0, count 0, lp_peak 0, hp_peak 0.
- rst overrides every other input on the same edge. Mid-capture reset returns to IDLE and the partial block is abandoned.
- start is sampled at edge N; busy=1 from cycle N+1.
- The final CAPTURE write at edge M gives busy=0 and done=1 from cycle M+1.
- count and peaks are registered; they reflect a write one cycle after its edge.
- Read latency is 1: rd_req at edge R gives rd_valid=1 with data in cycle R+1.
- Back-to-back reads sustain one per cycle.
- rd_lp/rd_hp hold their last value while rd_valid=0.
- rd_valid is a single-cycle pulse per accepted request.

## Test plan
Each bench uses DEPTH_LOG2=4 and SETTLE=2.
- Basic capture: pulse start, then drive 18 consecutive valid pairs with lp=k, hp=0x8000_0000|k for k=0..17.
  - Required: done rises the cycle after pair 17, count=16.
  - Reading rd_addr=0 returns lp=2, hp=0x8000_0002; rd_addr=15 returns lp=17.
- Gapped valid: same stimulus with sample_valid low on alternate cycles.
  - Required: identical stored contents and count=16; done asserts only after the 18th valid pair.
- Peak sign-magnitude: capture a block containing 0x8000_0100 (negative 256), 0x0000_00FF and 0xFFFF_FFFF.
  - Required: lp_peak=0x7FFF_FFFF.
  - A block of only 0x8000_0000 and 0 gives peak 0.
- Reset mid-capture: assert rst after 5 stored pairs.
  - Required: next cycle busy=0, done=0, count=0, peaks 0.
  - rd_req issued afterward gives rd_valid=0.
- DONE collisions: in DONE, issue rd_req for addrs 3,4,5 on consecutive cycles.
  - Required: rd_valid high for 3 cycles, data in order.
  - Then assert start with rd_req on the same cycle. Required: rd_valid=0, busy=1 next cycle, done=0.
- Ignored commands: start during SETTLE and CAPTURE, rd_req during CAPTURE.
  - Required: capture completes unchanged, count=16, rd_valid never asserts before done.
